// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the status telemetry framer.
// Frame layout: HEADER, seq, LEN, payload (ch0 first, MSB byte first), XOR checksum.
package telemetry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         MAX_PAYLOAD_W  = 256;

    function automatic int payload_len(input int num_ch, input int ch_w);
        return (num_ch * ch_w) / 8;
    endfunction

    // Byte idx of the wire payload; within a channel the MSB byte goes first.
    function automatic logic [7:0] payload_byte(input logic [MAX_PAYLOAD_W-1:0] snap,
                                                 input int ch_w, input int idx);
        int bpc;
        int off;
        bpc = ch_w / 8;
        off = (idx / bpc) * ch_w + (bpc - 1 - (idx % bpc)) * 8;
        if (off < 0 || off > MAX_PAYLOAD_W - 8)
            return 8'h00;
        return snap[off[7:0] +: 8];
    endfunction

endpackage

// File: rtl/telemetry_framer_period_timer.sv
// Free-running period counter; one-cycle tick when it reaches PERIOD_CYCLES-1.
// Held at zero while disabled so the first tick comes a full period after enable.
module period_timer #(
    parameter int PERIOD_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int            CW   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || !enable)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/telemetry_framer.sv
// Snapshots NUM_CH status channels and streams them as a framed, XOR-checksummed
// packet over the uart_tx valid/ready byte interface.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int         NUM_CH        = 4,
    parameter int         CH_W          = 8,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT,
    parameter int         PERIOD_CYCLES = 2_500_000,
    parameter bit         ON_CHANGE_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic                   enable,
    input  logic                   send_now,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [7:0]             seq,
    output logic [15:0]            frame_count,
    output logic [7:0]             dropped_count
);
    localparam int         PW       = NUM_CH * CH_W;
    localparam int         LEN      = payload_len(NUM_CH, CH_W);
    localparam logic [7:0] LEN_B    = 8'(LEN);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t                   state;
    logic [PW-1:0]            snap;
    logic [PW-1:0]            last_sent;
    logic [MAX_PAYLOAD_W-1:0] snap_ext;
    logic [7:0]               csum;
    logic [7:0]               byte_idx;
    logic [7:0]               nxt_idx;
    logic [7:0]               next_pl;
    logic                     pending;
    logic                     tick;
    logic                     xfer;
    logic                     trig_busy;
    logic                     trig_idle;

    period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_period_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign xfer      = tx_valid & tx_ready;
    assign trig_busy = send_now | tick;
    assign trig_idle = trig_busy | (ON_CHANGE_EN && enable && (ch_data != last_sent));
    assign snap_ext  = MAX_PAYLOAD_W'(snap);
    assign nxt_idx   = (state == ST_LEN) ? 8'd0 : byte_idx + 8'd1;
    assign next_pl   = payload_byte(snap_ext, CH_W, int'(nxt_idx));

    // csum holds the XOR of every non-header byte loaded so far, so it is the
    // checksum itself by the time the last payload byte has been accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            busy          <= 1'b0;
            seq           <= 8'h00;
            frame_count   <= 16'h0000;
            dropped_count <= 8'h00;
            pending       <= 1'b0;
            last_sent     <= '0;
            csum          <= 8'h00;
            byte_idx      <= 8'h00;
        end else begin
            if (busy && trig_busy && !(xfer && state == ST_CSUM)) begin
                if (!pending)
                    pending <= 1'b1;
                else if (dropped_count != 8'hFF)
                    dropped_count <= dropped_count + 8'd1;
            end
            case (state)
                ST_IDLE: if (trig_idle) begin
                    snap     <= ch_data;
                    state    <= ST_HDR;
                    tx_data  <= HEADER;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                    csum     <= 8'h00;
                end
                ST_HDR: if (xfer) begin
                    state   <= ST_SEQ;
                    tx_data <= seq;
                    csum    <= csum ^ seq;
                end
                ST_SEQ: if (xfer) begin
                    state   <= ST_LEN;
                    tx_data <= LEN_B;
                    csum    <= csum ^ LEN_B;
                end
                ST_LEN: if (xfer) begin
                    state    <= ST_PAYLOAD;
                    byte_idx <= 8'd0;
                    tx_data  <= next_pl;
                    csum     <= csum ^ next_pl;
                end
                ST_PAYLOAD: if (xfer) begin
                    if (byte_idx == LAST_IDX) begin
                        state   <= ST_CSUM;
                        tx_data <= csum;
                    end else begin
                        byte_idx <= nxt_idx;
                        tx_data  <= next_pl;
                        csum     <= csum ^ next_pl;
                    end
                end
                ST_CSUM: if (xfer) begin
                    seq         <= seq + 8'd1;
                    frame_count <= frame_count + 16'd1;
                    last_sent   <= snap;
                    // A trigger landing on the checksum cycle is served by this
                    // back-to-back frame rather than being counted as a drop.
                    if (pending || trig_busy) begin
                        pending <= pending & trig_busy;
                        snap    <= ch_data;
                        state   <= ST_HDR;
                        tx_data <= HEADER;
                        csum    <= 8'h00;
                    end else begin
                        state    <= ST_IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: four instances cover 8-bit/16-bit channels,
// periodic and on-change triggering; expected bytes are hand-computed.
module tb_telemetry_framer;

    logic        CLOCK_50;
    logic        reset;
    logic [15:0] ch_data       [4];
    logic        enable        [4];
    logic        send_now      [4];
    logic        tx_ready      [4];
    logic [7:0]  tx_data       [4];
    logic        tx_valid      [4];
    logic        busy          [4];
    logic [7:0]  seq           [4];
    logic [15:0] frame_count   [4];
    logic [7:0]  dropped_count [4];

    int vectors = 0;
    int miscompares = 0;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Instance 0: 2 x 8-bit channels, send_now only.
    telemetry_framer #(.NUM_CH(2), .CH_W(8), .PERIOD_CYCLES(1_000_000), .ON_CHANGE_EN(1'b0)) u_a (
        .clk(CLOCK_50), .reset(reset), .ch_data(ch_data[0]), .enable(enable[0]),
        .send_now(send_now[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .seq(seq[0]),
        .frame_count(frame_count[0]), .dropped_count(dropped_count[0]));

    // Instance 1: periodic frames every 100 cycles.
    telemetry_framer #(.NUM_CH(2), .CH_W(8), .PERIOD_CYCLES(100), .ON_CHANGE_EN(1'b0)) u_b (
        .clk(CLOCK_50), .reset(reset), .ch_data(ch_data[1]), .enable(enable[1]),
        .send_now(send_now[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .seq(seq[1]),
        .frame_count(frame_count[1]), .dropped_count(dropped_count[1]));

    // Instance 2: on-change trigger with a long period.
    telemetry_framer #(.NUM_CH(2), .CH_W(8), .PERIOD_CYCLES(1_000_000), .ON_CHANGE_EN(1'b1)) u_c (
        .clk(CLOCK_50), .reset(reset), .ch_data(ch_data[2]), .enable(enable[2]),
        .send_now(send_now[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .busy(busy[2]), .seq(seq[2]),
        .frame_count(frame_count[2]), .dropped_count(dropped_count[2]));

    // Instance 3: one 16-bit channel.
    telemetry_framer #(.NUM_CH(1), .CH_W(16), .PERIOD_CYCLES(1_000_000), .ON_CHANGE_EN(1'b0)) u_d (
        .clk(CLOCK_50), .reset(reset), .ch_data(ch_data[3]), .enable(enable[3]),
        .send_now(send_now[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .busy(busy[3]), .seq(seq[3]),
        .frame_count(frame_count[3]), .dropped_count(dropped_count[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for a transfer, returns its byte and
    // moves to the negedge after it. Timeout yields X so the caller's check fails.
    task automatic next_byte(input int sel, output logic [7:0] b);
        b = 8'hxx;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid[sel] && tx_ready[sel]) begin
                b = tx_data[sel];
                @(negedge CLOCK_50);
                return;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic chk_byte(input int sel, input string tag, input logic [7:0] exp);
        logic [7:0] b;
        next_byte(sel, b);
        chk(tag, {24'h0, b}, {24'h0, exp});
    endtask

    task automatic expect_frame(input int sel, input string tag,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
        chk_byte(sel, {tag, "_hdr"},  e0);
        chk_byte(sel, {tag, "_seq"},  e1);
        chk_byte(sel, {tag, "_len"},  e2);
        chk_byte(sel, {tag, "_p0"},   e3);
        chk_byte(sel, {tag, "_p1"},   e4);
        chk_byte(sel, {tag, "_csum"}, e5);
    endtask

    task automatic send(input int sel);
        send_now[sel] = 1'b1;
        @(negedge CLOCK_50);
        send_now[sel] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, rises;
        logic prev;

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enable[i]   = 1'b0;
            send_now[i] = 1'b0;
            tx_ready[i] = 1'b1;
            ch_data[i]  = 16'h0000;
        end
        ch_data[0] = 16'h813C;
        ch_data[1] = 16'h1234;
        ch_data[3] = 16'hBEEF;
        enable[2]  = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        chk("rst_valid",   32'(tx_valid[0]),      0);
        chk("rst_data",    32'(tx_data[0]),       0);
        chk("rst_busy",    32'(busy[0]),          0);
        chk("rst_seq",     32'(seq[0]),           0);
        chk("rst_frames",  32'(frame_count[0]),   0);
        chk("rst_dropped", 32'(dropped_count[0]), 0);
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Basic frame, including one-cycle trigger-to-header latency.
        send(0);
        chk("lat_busy",  32'(busy[0]),     1);
        chk("lat_valid", 32'(tx_valid[0]), 1);
        chk("lat_data",  32'(tx_data[0]),  32'hA5);
        expect_frame(0, "basic", 8'hA5, 8'h00, 8'h02, 8'h3C, 8'h81, 8'hBF);
        chk("basic_seq",    32'(seq[0]),         1);
        chk("basic_frames", 32'(frame_count[0]), 1);
        chk("basic_busy",   32'(busy[0]),        0);

        // Backpressure on the LEN byte.
        send(0);
        chk_byte(0, "bp_hdr", 8'hA5);
        chk_byte(0, "bp_seq", 8'h01);
        tx_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 32'(tx_valid[0]), 1);
            chk("bp_hold_data",  32'(tx_data[0]),  32'h02);
            @(negedge CLOCK_50);
        end
        tx_ready[0] = 1'b1;
        chk_byte(0, "bp_len",  8'h02);
        chk_byte(0, "bp_p0",   8'h3C);
        chk_byte(0, "bp_p1",   8'h81);
        chk_byte(0, "bp_csum", 8'hBE);
        chk("bp_seq", 32'(seq[0]), 2);

        // Overrun: starting pulse plus two more mid-frame.
        send(0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            logic [7:0] exp_b [6];
            exp_b = '{8'hA5, 8'h02, 8'h02, 8'h3C, 8'h81, 8'hBD};
            send_now[0] = (i == 1 || i == 3);
            next_byte(0, b);
            chk("ovr_first", {24'h0, b}, {24'h0, exp_b[i]});
        end
        send_now[0] = 1'b0;
        chk("ovr_b2b_valid", 32'(tx_valid[0]),      1);
        chk("ovr_b2b_data",  32'(tx_data[0]),       32'hA5);
        chk("ovr_b2b_busy",  32'(busy[0]),          1);
        chk("ovr_dropped",   32'(dropped_count[0]), 1);
        expect_frame(0, "ovr_second", 8'hA5, 8'h03, 8'h02, 8'h3C, 8'h81, 8'hBC);
        chk("ovr_busy",   32'(busy[0]),        0);
        chk("ovr_frames", 32'(frame_count[0]), 4);
        repeat (10) @(negedge CLOCK_50);
        chk("ovr_no_third", 32'(frame_count[0]), 4);

        // Periodic frames 100 cycles apart.
        enable[1] = 1'b1;
        first = -1; second = -1; rises = 0; prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLOCK_50);
            if (busy[1] && !prev) begin
                rises++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            prev = busy[1];
        end
        enable[1] = 1'b0;
        chk("per_first", 32'(first),          99);
        chk("per_gap",   32'(second - first), 100);
        chk("per_rises", 32'(rises),          4);
        repeat (300) @(negedge CLOCK_50);
        chk("per_off_frames", 32'(frame_count[1]), 4);
        chk("per_off_busy",   32'(busy[1]),        0);

        // On-change: stable zero data sends nothing, a change to ch0 sends one frame.
        chk("chg_idle_frames", 32'(frame_count[2]), 0);
        ch_data[2] = 16'h0007;
        @(negedge CLOCK_50);
        expect_frame(2, "chg", 8'hA5, 8'h00, 8'h02, 8'h07, 8'h00, 8'h05);
        repeat (50) @(negedge CLOCK_50);
        chk("chg_frames", 32'(frame_count[2]), 1);
        chk("chg_busy",   32'(busy[2]),        0);

        // 16-bit channel and sequence wrap.
        send(3);
        expect_frame(3, "w16", 8'hA5, 8'h00, 8'h02, 8'hBE, 8'hEF, 8'h53);
        for (int k = 1; k < 256; k++) begin
            send(3);
            expect_frame(3, "wrap", 8'hA5, 8'(k), 8'h02, 8'hBE, 8'hEF, 8'(k) ^ 8'h53);
        end
        chk("wrap_seq",    32'(seq[3]),         0);
        chk("wrap_frames", 32'(frame_count[3]), 256);

        // Reset in the middle of the payload.
        send(0);
        chk_byte(0, "mid_hdr", 8'hA5);
        chk_byte(0, "mid_seq", 8'h04);
        chk_byte(0, "mid_len", 8'h02);
        chk_byte(0, "mid_p0",  8'h3C);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("mid_rst_valid",  32'(tx_valid[0]),    0);
        chk("mid_rst_busy",   32'(busy[0]),        0);
        chk("mid_rst_seq",    32'(seq[0]),         0);
        chk("mid_rst_frames", 32'(frame_count[0]), 0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        send(0);
        expect_frame(0, "post_rst", 8'hA5, 8'h00, 8'h02, 8'h3C, 8'h81, 8'hBF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
